// File: rtl/text_buffer_ctrl.sv
// Character-buffer controller: merges two byte sources into a ROWS x COLS screen RAM.
// Handles the CR/LF/BS/FF control codes and provides a registered read port for the text generator.
module text_buffer_ctrl #(
    parameter int unsigned COLS      = 32,
    parameter int unsigned ROWS      = 8,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned WRAP_MODE = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ch0_valid,
    input  logic [DATA_W-1:0]        ch0_data,
    output logic                     ch0_ready,
    input  logic                     ch1_valid,
    input  logic [DATA_W-1:0]        ch1_data,
    output logic                     ch1_ready,
    input  logic                     clear,
    input  logic [$clog2(ROWS)-1:0]  rd_row,
    input  logic [$clog2(COLS)-1:0]  rd_col,
    output logic [DATA_W-1:0]        rd_data,
    output logic [$clog2(ROWS)-1:0]  cursor_row,
    output logic [$clog2(COLS)-1:0]  cursor_col,
    output logic [DATA_W-1:0]        last_char,
    output logic                     char_stb,
    output logic                     busy,
    output logic                     full
);

    localparam int unsigned ROW_W  = $clog2(ROWS);
    localparam int unsigned COL_W  = $clog2(COLS);
    localparam int unsigned CELLS  = ROWS * COLS;
    localparam int unsigned ADDR_W = $clog2(CELLS);

    localparam logic [DATA_W-1:0] SPACE   = DATA_W'(8'h20);
    localparam logic [7:0]        CODE_BS = 8'h08;
    localparam logic [7:0]        CODE_LF = 8'h0A;
    localparam logic [7:0]        CODE_FF = 8'h0C;
    localparam logic [7:0]        CODE_CR = 8'h0D;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   fill_q, fill_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic                full_q, full_d;
    logic [DATA_W-1:0]   last_char_q, last_char_d;
    logic                char_stb_q, char_stb_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;

    logic [DATA_W-1:0]   mem_q [CELLS];

    logic                we;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data;
    logic                do_newline;

    logic                idle;
    logic                ch0_acc;
    logic                ch1_acc;
    logic                accept;
    logic [DATA_W-1:0]   in_byte;
    logic [7:0]          code;
    logic                printable;
    logic [ADDR_W-1:0]   cursor_addr;
    logic [ADDR_W-1:0]   rd_addr;
    logic                rd_in_range;

    // Handshake: ch0 always wins, and a clear request blocks both sources
    assign idle      = (state_q == ST_IDLE);
    assign ch0_ready = idle & ~clear;
    assign ch1_ready = idle & ~clear & ~ch0_valid;
    assign ch0_acc   = ch0_valid & ch0_ready;
    assign ch1_acc   = ch1_valid & ch1_ready;
    assign accept    = ch0_acc | ch1_acc;
    assign in_byte   = ch0_acc ? ch0_data : ch1_data;
    assign code      = 8'(in_byte);
    assign printable = (code >= 8'h20) && (code <= 8'h7E);

    assign cursor_addr = ADDR_W'(ADDR_W'(row_q) * ADDR_W'(COLS)) + ADDR_W'(col_q);
    assign rd_addr     = ADDR_W'(ADDR_W'(rd_row) * ADDR_W'(COLS)) + ADDR_W'(rd_col);
    assign rd_in_range = ({1'b0, rd_row} < (ROW_W+1)'(ROWS)) &&
                         ({1'b0, rd_col} < (COL_W+1)'(COLS));

    // Next-state, cursor and RAM write-port decode
    always_comb begin
        state_d     = state_q;
        fill_d      = fill_q;
        row_d       = row_q;
        col_d       = col_q;
        full_d      = full_q;
        last_char_d = last_char_q;
        char_stb_d  = 1'b0;
        we          = 1'b0;
        wr_addr     = cursor_addr;
        wr_data     = SPACE;
        do_newline  = 1'b0;

        case (state_q)
            ST_CLEAR: begin
                we      = 1'b1;
                wr_addr = fill_q;
                row_d   = '0;
                col_d   = '0;
                full_d  = 1'b0;
                if (fill_q == ADDR_W'(CELLS - 1)) begin
                    state_d = ST_IDLE;
                    fill_d  = '0;
                end else begin
                    fill_d = fill_q + ADDR_W'(1);
                end
            end

            ST_IDLE: begin
                if (clear || (accept && code == CODE_FF)) begin
                    state_d = ST_CLEAR;
                    fill_d  = '0;
                    row_d   = '0;
                    col_d   = '0;
                    full_d  = 1'b0;
                end else if (accept) begin
                    if (printable) begin
                        if (!full_q) begin
                            we          = 1'b1;
                            wr_data     = in_byte;
                            last_char_d = in_byte;
                            char_stb_d  = 1'b1;
                            if (col_q != COL_W'(COLS - 1)) begin
                                col_d = col_q + COL_W'(1);
                            end else begin
                                do_newline = 1'b1;
                            end
                        end
                    end else if (code == CODE_CR) begin
                        col_d = '0;
                    end else if (code == CODE_LF) begin
                        do_newline = 1'b1;
                    end else if (code == CODE_BS) begin
                        full_d = 1'b0;
                        // Previous cell is always cursor_addr-1 in row-major order
                        if (col_q != '0) begin
                            col_d   = col_q - COL_W'(1);
                            we      = 1'b1;
                            wr_addr = cursor_addr - ADDR_W'(1);
                        end else if (row_q != '0) begin
                            row_d   = row_q - ROW_W'(1);
                            col_d   = COL_W'(COLS - 1);
                            we      = 1'b1;
                            wr_addr = cursor_addr - ADDR_W'(1);
                        end
                    end
                end
            end

            default: begin
                state_d = ST_CLEAR;
                fill_d  = '0;
            end
        endcase

        // Shared end-of-line handling for printables and LF
        if (do_newline) begin
            if (row_q != ROW_W'(ROWS - 1)) begin
                row_d = row_q + ROW_W'(1);
                col_d = '0;
            end else if (WRAP_MODE == 0) begin
                row_d = '0;
                col_d = '0;
            end else begin
                row_d  = ROW_W'(ROWS - 1);
                col_d  = COL_W'(COLS - 1);
                full_d = 1'b1;
            end
        end

        // Blank the read port while the screen is being wiped
        rd_data_d = (idle && rd_in_range) ? mem_q[rd_addr] : SPACE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_CLEAR;
            fill_q      <= '0;
            row_q       <= '0;
            col_q       <= '0;
            full_q      <= 1'b0;
            last_char_q <= '0;
            char_stb_q  <= 1'b0;
            rd_data_q   <= SPACE;
        end else begin
            state_q     <= state_d;
            fill_q      <= fill_d;
            row_q       <= row_d;
            col_q       <= col_d;
            full_q      <= full_d;
            last_char_q <= last_char_d;
            char_stb_q  <= char_stb_d;
            rd_data_q   <= rd_data_d;
        end
    end

    // Screen RAM: contents are initialised by the CLEAR sweep, not by reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data    = rd_data_q;
    assign cursor_row = row_q;
    assign cursor_col = col_q;
    assign last_char  = last_char_q;
    assign char_stb   = char_stb_q;
    assign busy       = ~idle;
    assign full       = full_q;

endmodule

// File: tb/tb_text_buffer_ctrl.sv
// Directed bench for text_buffer_ctrl at COLS=4, ROWS=2.
// One instance wraps at end of screen and the other stops and flags full.
module tb_text_buffer_ctrl;

    localparam int unsigned COLS   = 4;
    localparam int unsigned ROWS   = 2;
    localparam int unsigned DATA_W = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              ch0_valid, ch1_valid, clear;
    logic [DATA_W-1:0] ch0_data, ch1_data;
    logic [0:0]        rd_row;
    logic [1:0]        rd_col;

    logic              ch0_ready_w, ch1_ready_w, char_stb_w, busy_w, full_w;
    logic [DATA_W-1:0] rd_data_w, last_char_w;
    logic [0:0]        cursor_row_w;
    logic [1:0]        cursor_col_w;

    logic              ch0_ready_f, ch1_ready_f, char_stb_f, busy_f, full_f;
    logic [DATA_W-1:0] rd_data_f, last_char_f;
    logic [0:0]        cursor_row_f;
    logic [1:0]        cursor_col_f;

    int checks = 0;
    int errors = 0;
    int n;
    string s;

    always #5 clk = ~clk;

    text_buffer_ctrl #(.COLS(COLS), .ROWS(ROWS), .DATA_W(DATA_W), .WRAP_MODE(0)) u_wrap (
        .clk(clk), .reset(reset),
        .ch0_valid(ch0_valid), .ch0_data(ch0_data), .ch0_ready(ch0_ready_w),
        .ch1_valid(ch1_valid), .ch1_data(ch1_data), .ch1_ready(ch1_ready_w),
        .clear(clear), .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data_w),
        .cursor_row(cursor_row_w), .cursor_col(cursor_col_w), .last_char(last_char_w),
        .char_stb(char_stb_w), .busy(busy_w), .full(full_w)
    );

    text_buffer_ctrl #(.COLS(COLS), .ROWS(ROWS), .DATA_W(DATA_W), .WRAP_MODE(1)) u_full (
        .clk(clk), .reset(reset),
        .ch0_valid(ch0_valid), .ch0_data(ch0_data), .ch0_ready(ch0_ready_f),
        .ch1_valid(ch1_valid), .ch1_data(ch1_data), .ch1_ready(ch1_ready_f),
        .clear(clear), .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data_f),
        .cursor_row(cursor_row_f), .cursor_col(cursor_col_f), .last_char(last_char_f),
        .char_stb(char_stb_f), .busy(busy_f), .full(full_f)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send0(input logic [7:0] b);
        ch0_valid = 1'b1;
        ch0_data  = b;
        tick();
        ch0_valid = 1'b0;
    endtask

    task automatic cur_w(input string tag, input int r, input int c);
        check({tag, ".w.row"}, 32'(cursor_row_w), 32'(r));
        check({tag, ".w.col"}, 32'(cursor_col_w), 32'(c));
    endtask

    task automatic cur_f(input string tag, input int r, input int c);
        check({tag, ".f.row"}, 32'(cursor_row_f), 32'(r));
        check({tag, ".f.col"}, 32'(cursor_col_f), 32'(c));
    endtask

    task automatic rd(input string tag, input int r, input int c,
                      input logic [7:0] exp_w, input logic [7:0] exp_f);
        rd_row = 1'(r);
        rd_col = 2'(c);
        tick();
        check({tag, ".w"}, 32'(rd_data_w), 32'(exp_w));
        check({tag, ".f"}, 32'(rd_data_f), 32'(exp_f));
    endtask

    // Count busy cycles with a bound; clear is pulsed mid-sweep when pulse_at >= 0
    task automatic wait_clear(input string tag, input int pulse_at);
        n = 0;
        while (busy_w && n < 20) begin
            clear = (n == pulse_at);
            check({tag, ".ready0"}, 32'(ch0_ready_w | ch0_ready_f), 32'd0);
            check({tag, ".ready1"}, 32'(ch1_ready_w | ch1_ready_f), 32'd0);
            tick();
            n++;
        end
        clear = 1'b0;
        check({tag, ".len"}, 32'(n), 32'd8);
        check({tag, ".busy_f"}, 32'(busy_f), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        ch0_valid = 1'b1;
        ch0_data  = 8'h41;
        ch1_valid = 1'b0;
        ch1_data  = 8'h00;
        clear     = 1'b0;
        rd_row    = '0;
        rd_col    = '0;
        repeat (2) @(posedge clk);
        #1;

        check("rst.busy", 32'(busy_w & busy_f), 32'd1);
        cur_w("rst", 0, 0);
        check("rst.last", 32'(last_char_w), 32'h00);
        check("rst.stb", 32'(char_stb_w | char_stb_f), 32'd0);
        check("rst.full", 32'(full_f), 32'd0);
        check("rst.rd", 32'(rd_data_w), 32'h20);

        // Initial sweep with ch0 already offering 'A'
        reset = 1'b0;
        n = 0;
        while (busy_w && n < 20) begin
            check("init.ready", 32'(ch0_ready_w), 32'd0);
            check("init.rd", 32'(rd_data_w), 32'h20);
            tick();
            n++;
        end
        check("init.len", 32'(n), 32'd8);
        check("init.ready9", 32'(ch0_ready_w & ch0_ready_f), 32'd1);

        s = "ABCDE";
        for (int i = 0; i < 5; i++) begin
            ch0_valid = 1'b1;
            ch0_data  = s[i];
            tick();
            check("abcde.stb_w", 32'(char_stb_w), 32'd1);
            check("abcde.stb_f", 32'(char_stb_f), 32'd1);
        end
        ch0_valid = 1'b0;
        tick();
        check("abcde.stb_off", 32'(char_stb_w | char_stb_f), 32'd0);
        cur_w("abcde", 1, 1);
        cur_f("abcde", 1, 1);
        check("abcde.last", 32'(last_char_w), 32'h45);
        rd("rd00", 0, 0, 8'h41, 8'h41);
        rd("rd01", 0, 1, 8'h42, 8'h42);
        rd("rd02", 0, 2, 8'h43, 8'h43);
        rd("rd03", 0, 3, 8'h44, 8'h44);
        rd("rd10", 1, 0, 8'h45, 8'h45);
        rd("rd11", 1, 1, 8'h20, 8'h20);

        // Both sources valid: ch0 first, ch1 stalls then follows
        ch0_valid = 1'b1; ch0_data = 8'h58;
        ch1_valid = 1'b1; ch1_data = 8'h59;
        #1;
        check("prio.r0", 32'(ch0_ready_w), 32'd1);
        check("prio.r1", 32'(ch1_ready_w), 32'd0);
        tick();
        ch0_valid = 1'b0;
        #1;
        check("prio.r1b", 32'(ch1_ready_w), 32'd1);
        tick();
        ch1_valid = 1'b0;
        cur_w("prio", 1, 3);
        check("prio.last", 32'(last_char_w), 32'h59);
        rd("prio.x", 1, 1, 8'h58, 8'h58);
        rd("prio.y", 1, 2, 8'h59, 8'h59);

        // Backspace across the row boundary and at the origin
        repeat (3) send0(8'h08);
        cur_w("bs3", 1, 0);
        send0(8'h08);
        cur_w("bs_wrap", 0, 3);
        check("bs.stb", 32'(char_stb_w), 32'd0);
        rd("bs.d", 0, 3, 8'h20, 8'h20);
        rd("bs.e", 1, 0, 8'h20, 8'h20);
        repeat (3) send0(8'h08);
        cur_w("bs_org", 0, 0);
        send0(8'h08);
        cur_w("bs_noop", 0, 0);
        cur_f("bs_noop", 0, 0);
        rd("bs.a", 0, 0, 8'h20, 8'h20);

        // End-of-screen: wrap vs stop-and-flag
        s = "abcdefghi";
        for (int i = 0; i < 8; i++) send0(s[i]);
        check("eos8.full_f", 32'(full_f), 32'd1);
        check("eos8.full_w", 32'(full_w), 32'd0);
        cur_f("eos8", 1, 3);
        cur_w("eos8", 0, 0);
        send0(s[8]);
        check("eos9.stb_w", 32'(char_stb_w), 32'd1);
        check("eos9.stb_f", 32'(char_stb_f), 32'd0);
        cur_w("eos9", 0, 1);
        cur_f("eos9", 1, 3);
        check("eos9.last_w", 32'(last_char_w), 32'h69);
        check("eos9.last_f", 32'(last_char_f), 32'h68);
        check("eos9.full_f", 32'(full_f), 32'd1);
        rd("eos.c00", 0, 0, 8'h69, 8'h61);
        rd("eos.c13", 1, 3, 8'h68, 8'h68);
        send0(8'h08);
        check("eos.bs_full", 32'(full_f), 32'd0);
        cur_f("eos.bs", 1, 2);
        cur_w("eos.bs", 0, 0);

        // clear beats a same-cycle ch1 byte; a second clear mid-sweep is ignored
        ch1_valid = 1'b1;
        ch1_data  = 8'h5A;
        clear     = 1'b1;
        #1;
        check("clr.r1", 32'(ch1_ready_w | ch1_ready_f), 32'd0);
        tick();
        clear = 1'b0;
        cur_w("clr.start", 0, 0);
        wait_clear("clr", 3);
        cur_w("clr.end", 0, 0);
        cur_f("clr.end", 0, 0);
        check("clr.fullf", 32'(full_f), 32'd0);
        check("clr.r1b", 32'(ch1_ready_w), 32'd1);
        tick();
        ch1_valid = 1'b0;
        cur_w("clr.z", 0, 1);
        check("clr.last", 32'(last_char_f), 32'h5A);
        rd("clr.c00", 0, 0, 8'h5A, 8'h5A);
        rd("clr.c01", 0, 1, 8'h20, 8'h20);
        rd("clr.c13", 1, 3, 8'h20, 8'h20);

        // CR / LF including LF on the last row
        send0(8'h0A);
        cur_w("lf", 1, 0);
        send0(8'h51);
        send0(8'h0D);
        cur_w("cr", 1, 0);
        send0(8'h0A);
        cur_w("lf_last", 0, 0);
        cur_f("lf_last", 1, 3);
        check("lf_last.full_f", 32'(full_f), 32'd1);
        check("lf_last.full_w", 32'(full_w), 32'd0);

        // FF behaves like the clear input
        send0(8'h0C);
        check("ff.busy", 32'(busy_w & busy_f), 32'd1);
        wait_clear("ff", -1);
        cur_f("ff", 0, 0);
        check("ff.full_f", 32'(full_f), 32'd0);
        rd("ff.c10", 1, 0, 8'h20, 8'h20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
